// File: rtl/imem_loader_pkg.sv
// Shared types and sizing for the instruction-memory loader.
package imem_loader_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DEPTH  = 1 << IMEM_ADDR_W;
  localparam int INSTR_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_wr_ptr.sv
// Word-address counter shared by the zero-fill sweep and the program load,
// with a separate program-word count and a sticky overflow flag.
module imem_loader_wr_ptr
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              cnt_i,
  input  logic              ovf_set_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              tc_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      ptr_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      // The pointer wraps to 0 after the last address, which hands LOAD a fresh start.
      if (inc_i)           ptr_d   = ptr_q + 1'b1;
      if (inc_i && cnt_i)  count_d = count_q + 1'b1;
      if (ovf_set_i)       ovf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ptr_o   = ptr_q;
  assign tc_o    = &ptr_q;
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/imem_loader.sv
// Zero-fills instruction memory, streams a program into it, then starts the CPU.
// Optional running checksum of accepted words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = INSTR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic              word_valid_i,
  input  logic [DATA_W-1:0] word_data_i,
  input  logic              word_last_i,
  output logic              word_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  output logic              cpu_start_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   words_loaded_o,
  output logic              overflow_o,
  output logic [DATA_W-1:0] checksum_o
);

  state_e            state_q, state_d;
  logic              hs;
  logic              ptr_clr;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_tc;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;

  assign word_ready_o = (state_q == ST_LOAD);
  assign hs           = word_valid_i && word_ready_o;
  // load_req_i only restarts from IDLE or RUN; mid-sequence requests are ignored.
  assign ptr_clr      = load_req_i && ((state_q == ST_IDLE) || (state_q == ST_RUN));

  imem_loader_wr_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (ptr_clr),
    .inc_i     ((state_q == ST_CLEAR) || hs),
    .cnt_i     (hs),
    .ovf_set_i (hs && ptr_tc && !word_last_i),
    .ptr_o     (ptr),
    .tc_o      (ptr_tc),
    .count_o   (words_loaded_o),
    .ovf_o     (overflow_o)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (load_req_i)                      state_d = ST_CLEAR;
      ST_CLEAR: if (ptr_tc)                          state_d = ST_LOAD;
      ST_LOAD:  if (hs && (word_last_i || ptr_tc))   state_d = ST_RUN;
      ST_RUN:   if (load_req_i)                      state_d = ST_CLEAR;
      default:                                       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d    = (state_q == ST_CLEAR) || hs;
    addr_d  = ptr;
    wdata_d = hs ? word_data_i : '0;
    busy_d  = (state_d == ST_CLEAR) || (state_d == ST_LOAD);
    // Start lags RUN entry by a cycle so the final write lands first.
    start_d = (state_q == ST_RUN) && (state_d == ST_RUN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_start_o  = start_q;
  assign busy_o       = busy_q;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (ptr_clr)  csum_d = '0;
    else if (hs)  csum_d = csum_q + word_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a memory-image model.
module tb_imem_loader;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst, load_req, word_valid, word_last;
  logic [DW-1:0] word_data;
  logic          word_ready, imem_we, cpu_start, busy, overflow;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata, checksum;
  logic [AW:0]   words_loaded;

  imem_loader dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .load_req_i     (load_req),
    .word_valid_i   (word_valid),
    .word_data_i    (word_data),
    .word_last_i    (word_last),
    .word_ready_o   (word_ready),
    .imem_we_o      (imem_we),
    .imem_addr_o    (imem_addr),
    .imem_wdata_o   (imem_wdata),
    .cpu_start_o    (cpu_start),
    .busy_o         (busy),
    .words_loaded_o (words_loaded),
    .overflow_o     (overflow),
    .checksum_o     (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] shadow_mem [DEPTH];
  logic [DW-1:0] exp_mem    [DEPTH];
  int            wr_addr_q  [$];
  logic [DW-1:0] wr_data_q  [$];
  int            wr_cyc_q   [$];
  logic [DW-1:0] prog       [$];

  int hs_last_cyc;
  int start_cyc;
  int accepted;

  // Memory-side observer: what the instruction memory would see.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      shadow_mem[imem_addr] <= imem_wdata;
      wr_addr_q.push_back(int'(imem_addr));
      wr_data_q.push_back(imem_wdata);
      wr_cyc_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  // Runs the zero-fill sweep from the cycle after load_req was sampled.
  task automatic run_clear(input string tag);
    int t = 0;
    int busy_bad = 0;
    int seq_bad = 0;
    clear_log();
    while (!word_ready && t < 400) begin
      if (busy !== 1'b1) busy_bad++;
      tick();
      t++;
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] != i || wr_data_q[i] !== '0) seq_bad++;
    check_eq({tag, "_clr_writes"}, wr_addr_q.size(), DEPTH);
    check_eq({tag, "_clr_seq"}, seq_bad, 0);
    check_eq({tag, "_clr_busy"}, busy_bad, 0);
    check_eq({tag, "_clr_ready"}, word_ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    $display("clear %s: %0d zero writes, ready=%0b", tag, wr_addr_q.size(), word_ready);
  endtask

  // mode 0: valid every cycle, 1: every other cycle, 2: random.
  task automatic send_prog(input int n, input bit mark_last, input int mode, input int stop_at);
    int t = 0;
    bit v;
    accepted    = 0;
    hs_last_cyc = -1;
    start_cyc   = -1;
    clear_log();
    while (start_cyc < 0 && t < 2000) begin
      v = (accepted < n) && ((mode == 0) || (mode == 1 && (t % 2) == 0) ||
                             (mode == 2 && $urandom_range(0, 1) == 1));
      word_valid = v;
      word_data  = v ? prog[accepted] : DW'($urandom);
      word_last  = v && mark_last && (accepted == n - 1);
      if (v && word_ready) begin
        hs_last_cyc = cyc;
        accepted++;
      end
      tick();
      t++;
      if (cpu_start === 1'b1 && start_cyc < 0) start_cyc = cyc;
      if (stop_at > 0 && accepted == stop_at) break;
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int n, input bit mark_last);
    int exp_acc;
    int seq_bad = 0;
    int mem_bad = 0;
    int ready_seen = 0;
    int wr_before;
    logic [DW-1:0] exp_sum = '0;
    bit exp_ovf;
    exp_acc = (n > DEPTH) ? DEPTH : n;
    exp_ovf = !mark_last && (n >= DEPTH);
    for (int i = 0; i < exp_acc; i++) begin
      exp_mem[i] = prog[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
      exp_sum = exp_sum + prog[i];
`endif
    end
    for (int i = 0; i < wr_addr_q.size(); i++)
      if (i >= exp_acc || wr_addr_q[i] != i || wr_data_q[i] !== prog[i]) seq_bad++;
    check_eq({tag, "_accepted"}, accepted, exp_acc);
    check_eq({tag, "_writes"}, wr_addr_q.size(), exp_acc);
    check_eq({tag, "_wr_seq"}, seq_bad, 0);
    if (wr_cyc_q.size() > 0)
      check_eq({tag, "_last_wr_lat"}, wr_cyc_q[wr_cyc_q.size()-1] - hs_last_cyc, 1);
    check_eq({tag, "_start_lat"}, start_cyc - hs_last_cyc, 2);
    check_eq({tag, "_words_loaded"}, words_loaded, exp_acc);
    check_eq({tag, "_overflow"}, overflow, exp_ovf);
    check_eq({tag, "_checksum"}, checksum, exp_sum);
    check_eq({tag, "_busy"}, busy, 1'b0);
    wr_before = wr_addr_q.size();
    // A further presented word must never be taken once running.
    word_valid = 1'b1;
    word_data  = DW'($urandom);
    for (int i = 0; i < 4; i++) begin
      if (word_ready !== 1'b0) ready_seen++;
      tick();
    end
    word_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq({tag, "_run_ready"}, ready_seen, 0);
    check_eq({tag, "_run_no_wr"}, wr_addr_q.size(), wr_before);
    check_eq({tag, "_start_held"}, cpu_start, 1'b1);
    for (int i = 0; i < DEPTH; i++)
      if (shadow_mem[i] !== exp_mem[i]) mem_bad++;
    check_eq({tag, "_mem_image"}, mem_bad, 0);
    $display("load %s: n=%0d accepted=%0d loaded=%0d ovf=%0b csum=0x%08h start_lat=%0d",
             tag, n, accepted, words_loaded, overflow, checksum, start_cyc - hs_last_cyc);
  endtask

  task automatic reload_from_run(input string tag);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    check_eq({tag, "_start_drop"}, cpu_start, 1'b0);
    check_eq({tag, "_loaded_clr"}, words_loaded, 0);
    check_eq({tag, "_ovf_clr"}, overflow, 1'b0);
    check_eq({tag, "_csum_clr"}, checksum, 0);
    check_eq({tag, "_busy_set"}, busy, 1'b1);
    run_clear(tag);
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back(DW'($urandom));
  endtask

  initial begin
    int n;
    rst = 1'b1; load_req = 1'b0; word_valid = 1'b0; word_last = 1'b0; word_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("rst_we", imem_we, 1'b0);
    check_eq("rst_addr", imem_addr, 0);
    check_eq("rst_wdata", imem_wdata, 0);
    check_eq("rst_start", cpu_start, 1'b0);
    check_eq("rst_ready", word_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_loaded", words_loaded, 0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_csum", checksum, 0);
    $display("reset: we=%0b start=%0b ready=%0b busy=%0b", imem_we, cpu_start, word_ready, busy);

    // Directed three-instruction program.
    pulse_load();
    run_clear("p3");
    prog = '{32'h00500093, 32'h00108133, 32'h002081B3};
    send_prog(3, 1'b1, 0, 0);
    check_result("p3", 3, 1'b1);

    // Valid toggling every other cycle.
    n = $urandom_range(10, 40);
    rand_prog(n);
    reload_from_run("tog");
    send_prog(n, 1'b1, 1, 0);
    check_result("tog", n, 1'b1);

    // Random valid gaps, including a single-word program.
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 1 : $urandom_range(2, 60);
      rand_prog(n);
      reload_from_run("rnd");
      send_prog(n, 1'b1, 2, 0);
      check_result("rnd", n, 1'b1);
    end

    // 257 words with no last marker: memory fills, overflow flagged.
    rand_prog(257);
    reload_from_run("ovf");
    send_prog(257, 1'b0, 0, 0);
    check_result("ovf", 257, 1'b0);

    // Reset after five accepted words.
    rand_prog(10);
    reload_from_run("rstm");
    send_prog(10, 1'b0, 0, 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rstm_we", imem_we, 1'b0);
    check_eq("rstm_start", cpu_start, 1'b0);
    check_eq("rstm_loaded", words_loaded, 0);
    check_eq("rstm_busy", busy, 1'b0);
    check_eq("rstm_ready", word_ready, 1'b0);
    tick();
    check_eq("rstm_idle_we", imem_we, 1'b0);
    $display("reset mid-load: accepted=%0d then we=%0b loaded=%0d", accepted, imem_we, words_loaded);
    pulse_load();
    run_clear("rl");
    rand_prog(3);
    send_prog(3, 1'b1, 2, 0);
    check_result("rl", 3, 1'b1);

    // Checksum wrap: 0xFFFFFFFF + 2.
    prog = '{32'hFFFFFFFF, 32'h00000002};
    reload_from_run("cs");
    send_prog(2, 1'b1, 0, 0);
    check_result("cs", 2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
